// File: rtl/ula_arbiter_if.sv
// ============================================================================
// ula_arbiter_if : request/response bundle between issuers and ula_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface ula_arbiter_if #(
  parameter int DATA_WIDTH = 20,
  parameter int OP_WIDTH   = 2
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [OP_WIDTH-1:0]   req0_control;
  logic [DATA_WIDTH-1:0] req0_opA;
  logic [DATA_WIDTH-1:0] req0_opB;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [OP_WIDTH-1:0]   req1_control;
  logic [DATA_WIDTH-1:0] req1_opA;
  logic [DATA_WIDTH-1:0] req1_opB;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [DATA_WIDTH-1:0] resp_result;
  logic                  resp_zero;

  modport master (
    output req0_valid, req0_control, req0_opA, req0_opB,
    input  req0_ready,
    output req1_valid, req1_control, req1_opA, req1_opB,
    input  req1_ready,
    input  resp_valid, resp_id, resp_result, resp_zero,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_control, req0_opA, req0_opB,
    output req0_ready,
    input  req1_valid, req1_control, req1_opA, req1_opB,
    output req1_ready,
    output resp_valid, resp_id, resp_result, resp_zero,
    input  resp_ready
  );
endinterface

`default_nettype wire

// File: rtl/ula_arbiter.sv
// ============================================================================
// ula_arbiter : round-robin sharing of one ULA between two requesters
// Revision 1.0
// ============================================================================
`default_nettype none

module ula_arbiter #(
  parameter int DATA_WIDTH = 20,
  parameter int OP_WIDTH   = 2
) (
  input  wire logic    clock,
  input  wire logic    reset,
  ula_arbiter_if.slave bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);

  state_t                state;
  state_t                next_state;
  logic                  last_served;
  logic                  grant;
  logic                  accept;
  logic [OP_WIDTH-1:0]   op_ctrl;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_id;
  logic [DATA_WIDTH-1:0] ula_result;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_served;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign busy           = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (bus.resp_valid && bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    case (op_ctrl)
      OP_ADD:  ula_result = op_a + op_b;
      OP_OR:   ula_result = op_a | op_b;
      OP_AND:  ula_result = op_a & op_b;
      default: ula_result = ~op_a;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_served     <= 1'b1;
      op_ctrl         <= '0;
      op_a            <= '0;
      op_b            <= '0;
      op_id           <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_id     <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_id   <= grant;
        op_ctrl <= grant ? bus.req1_control : bus.req0_control;
        op_a    <= grant ? bus.req1_opA     : bus.req0_opA;
        op_b    <= grant ? bus.req1_opB     : bus.req0_opB;
      end
      if (state == EXEC) begin
        bus.resp_result <= ula_result;
        bus.resp_zero   <= (op_a == op_b);
        bus.resp_id     <= op_id;
        bus.resp_valid  <= 1'b1;
      end
      if (state == RESP && bus.resp_valid && bus.resp_ready) begin
        bus.resp_valid <= 1'b0;
        last_served    <= bus.resp_id;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_arbiter.sv
// ============================================================================
// tb_ula_arbiter : directed self-checking bench for ula_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ula_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   compared   = 0;
  int   mismatched = 0;

  ula_arbiter_if #(.DATA_WIDTH(20), .OP_WIDTH(2)) bus ();

  ula_arbiter #(.DATA_WIDTH(20), .OP_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_control = 0; bus.req0_opA = 0; bus.req0_opB = 0;
    bus.req1_valid = 0; bus.req1_control = 0; bus.req1_opA = 0; bus.req1_opB = 0;
    bus.resp_ready = 0;
    do_reset();

    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_result", bus.resp_result, 0);
    chk("rst_resp_zero", bus.resp_zero, 0);
    chk("rst_ready0_idle", bus.req0_ready, 0);

    // single add 1+1
    bus.req0_valid = 1; bus.req0_control = 2'b00; bus.req0_opA = 20'h00001; bus.req0_opB = 20'h00001;
    #1;
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_valid", bus.resp_valid, 0);
    chk("t1_exec_ready0", bus.req0_ready, 0);
    tick();
    chk("t1_valid", bus.resp_valid, 1);
    chk("t1_id", bus.resp_id, 0);
    chk("t1_result", bus.resp_result, 32'h00002);
    chk("t1_zero", bus.resp_zero, 1);
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    chk("t1_done_valid", bus.resp_valid, 0);
    chk("t1_done_busy", busy, 0);

    // both valid after reset: req0 first
    do_reset();
    bus.req0_valid = 1; bus.req0_control = 2'b01; bus.req0_opA = 20'hFFC00; bus.req0_opB = 20'h00003;
    bus.req1_valid = 1; bus.req1_control = 2'b10; bus.req1_opA = 20'h00205; bus.req1_opB = 20'h0000F;
    #1;
    chk("t2_ready0", bus.req0_ready, 1);
    chk("t2_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    tick();
    chk("t2a_valid", bus.resp_valid, 1);
    chk("t2a_id", bus.resp_id, 0);
    chk("t2a_result", bus.resp_result, 32'hFFC03);
    chk("t2a_zero", bus.resp_zero, 0);
    chk("t2a_ready1_resp", bus.req1_ready, 0);
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    #1;
    chk("t2b_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 0;
    tick();
    chk("t2b_valid", bus.resp_valid, 1);
    chk("t2b_id", bus.resp_id, 1);
    chk("t2b_result", bus.resp_result, 32'h00005);
    chk("t2b_zero", bus.resp_zero, 0);
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_control = 2'b00; bus.req0_opA = 20'hFFFFF; bus.req0_opB = 20'h00001;
    #1;
    chk("t2c_ready0", bus.req0_ready, 1);
    chk("t2c_ready1", bus.req1_ready, 0);

    // add wrap, then backpressure with req1 still pending
    tick();
    bus.req0_valid = 0;
    tick();
    chk("t4_add_result", bus.resp_result, 32'h00000);
    chk("t4_add_zero", bus.resp_zero, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", bus.resp_valid, 1);
      chk("t3_hold_result", bus.resp_result, 32'h00000);
      chk("t3_hold_id", bus.resp_id, 0);
      chk("t3_hold_busy", busy, 1);
      chk("t3_hold_ready0", bus.req0_ready, 0);
      chk("t3_hold_ready1", bus.req1_ready, 0);
    end
    bus.resp_ready = 1;
    tick();
    bus.resp_ready = 0;
    chk("t3_release_valid", bus.resp_valid, 0);
    chk("t3_release_busy", busy, 0);
    chk("t3_release_ready1", bus.req1_ready, 1);

    // NOT from req1
    bus.req1_control = 2'b11; bus.req1_opA = 20'hFFC00; bus.req1_opB = 20'h00000;
    tick();
    bus.req1_valid = 0;
    tick();
    chk("t4_not_id", bus.resp_id, 1);
    chk("t4_not_result", bus.resp_result, 32'h003FF);
    chk("t4_not_zero", bus.resp_zero, 0);
    bus.resp_ready = 1;
    tick();

    // req0 alone so that req1 owns the next tie
    bus.req0_valid = 1; bus.req0_control = 2'b10; bus.req0_opA = 20'h12345; bus.req0_opB = 20'h12345;
    tick();
    bus.req0_valid = 0;
    tick();
    chk("t5_pre_result", bus.resp_result, 32'h12345);
    chk("t5_pre_zero", bus.resp_zero, 1);
    tick();
    bus.resp_ready = 0;
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    chk("t5_tie_ready1", bus.req1_ready, 1);
    chk("t5_tie_ready0", bus.req0_ready, 0);
    tick();
    chk("t5_exec_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_valid", bus.resp_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_post_ready0", bus.req0_ready, 1);
    chk("t5_post_ready1", bus.req1_ready, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    tick();
    tick();
    chk("t5_no_partial_valid", bus.resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
